// File: rtl/word_serializer.sv
// ---------------------------------------------------------------------------
// word_serializer
//
// Upstream feeder for the byte-wide serial-to-parallel shift stage. Each
// valid/ready handshake accepts one WORD_BYTES*BYTE_W-bit word. The word is
// then emitted as WORD_BYTES bytes, one byte per accepted output beat. The
// first and last beats of each word are flagged, downstream backpressure is
// honoured, and words can follow each other with no idle cycles between them.
// Each fully emitted word increments a wrapping counter.
//
// Parameters:
//   WORD_BYTES - bytes per input word (min 2)
//   BYTE_W     - bits per output byte
//   MSB_FIRST  - 0: emit in_data[BYTE_W-1:0] first; 1: emit the top byte first
//   CNT_W      - width of the completed-word counter
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = in reset)
//   in_data    in   word to serialize, sampled only on an input beat
//   in_valid   in   in_data valid
//   in_ready   out  block can accept a word this cycle (combinational)
//   out_data   out  current byte
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data this cycle
//   out_first  out  current byte is byte 0 of its word
//   out_last   out  current byte is the final byte of its word
//   abort      in   synchronous drop of the word in flight
//   busy       out  a word is being emitted
//   word_count out  number of words whose last byte completed; wraps
// ---------------------------------------------------------------------------
module word_serializer #(
    parameter int WORD_BYTES = 8,
    parameter int BYTE_W     = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_BYTES*BYTE_W-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BYTE_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_first,
    output logic                         out_last,
    input  logic                         abort,
    output logic                         busy,
    output logic [CNT_W-1:0]             word_count
);

    localparam int WORD_W = WORD_BYTES * BYTE_W;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [WORD_W-1:0]  shreg;
    logic [IDX_W-1:0]   idx;

    logic               at_last;
    logic               in_beat;
    logic               out_beat;
    logic               word_done;

    assign at_last = (idx == LAST_IDX);

    // A word completes only on the beat that hands over its final byte, and
    // an abort in that same cycle cancels the completion.
    assign in_beat   = in_valid & in_ready;
    assign out_beat  = out_valid & out_ready;
    assign word_done = out_beat & at_last & ~abort;

    // State register. Reset drops any word in flight immediately, so no
    // out_last is ever produced for it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Abort overrides everything and returns to IDLE.
    // On the last byte, a simultaneous input beat keeps us in SEND so the
    // next word follows without a bubble.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_beat) begin
                        next_state = SEND;
                    end
                end
                SEND: begin
                    if (out_beat && at_last) begin
                        next_state = in_beat ? SEND : IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // Output logic. in_ready opens either when idle or when the final byte
    // of the current word is being accepted. It is forced low while reset is
    // held or while an abort is being applied. out_data is always the byte
    // sitting at the output end of the shift register, so holding the
    // register under backpressure holds the byte as well.
    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND);
        out_first = (state == SEND) & (idx == '0);
        out_last  = (state == SEND) & at_last;
        in_ready  = reset & ~abort &
                    ((state == IDLE) | ((state == SEND) & out_ready & at_last));
        if (MSB_FIRST) begin
            out_data = shreg[WORD_W-1 -: BYTE_W];
        end else begin
            out_data = shreg[BYTE_W-1:0];
        end
    end

    // Datapath: shift register and byte index. A new word is loaded with the
    // index at 0. Every non-final accepted byte moves the next byte into the
    // output position. Under backpressure nothing changes, so data, flags
    // and index stay stable. An abort parks the index at 0. The discarded
    // word is never shown again because out_valid goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            idx   <= '0;
        end else if (abort) begin
            idx <= '0;
        end else if (in_beat) begin
            shreg <= in_data;
            idx   <= '0;
        end else if (out_beat && !at_last) begin
            if (MSB_FIRST) begin
                shreg <= shreg << BYTE_W;
            end else begin
                shreg <= shreg >> BYTE_W;
            end
            idx <= idx + 1'b1;
        end
    end

    // Completed-word counter. It wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
        end else if (word_done) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_word_serializer
//
// Drives two serializers from the same stimulus. One instance emits
// LSB-first and the other MSB-first. Every cycle, both are compared against
// a byte-position reference model. The model keeps the accepted word and
// the position of the byte being presented, and it derives each expected
// byte by slicing that word directly. The bench runs directed scenarios
// first and then a randomized phase.
// ---------------------------------------------------------------------------
module tb_word_serializer;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        abort;

    logic        ir0, ov0, of0, ol0, bz0;
    logic [7:0]  od0;
    logic [15:0] wc0;
    logic        ir1, ov1, of1, ol1, bz1;
    logic [7:0]  od1;
    logic [15:0] wc1;

    int total = 0;
    int bad   = 0;

    // Reference model: the word in flight and the position of the byte
    // currently presented, plus the completed-word count.
    bit          mActive;
    logic [63:0] mWord;
    int          mPos;
    logic [15:0] mCount;

    word_serializer #(.WORD_BYTES(8), .BYTE_W(8), .MSB_FIRST(1'b0), .CNT_W(16)) dutLsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .out_first(of0), .out_last(ol0), .abort(abort), .busy(bz0), .word_count(wc0)
    );

    word_serializer #(.WORD_BYTES(8), .BYTE_W(8), .MSB_FIRST(1'b1), .CNT_W(16)) dutMsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .out_first(of1), .out_last(ol1), .abort(abort), .busy(bz1), .word_count(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit expInReady();
        return reset && !abort && (!mActive || (out_ready && mPos == 7));
    endfunction

    // Compare every visible output of both instances against the model.
    task automatic compareAll();
        logic [7:0] bLsb;
        logic [7:0] bMsb;
        bit         ir;
        ir = expInReady();
        checkOutput("in_ready_lsb",  64'(ir0), 64'(ir));
        checkOutput("in_ready_msb",  64'(ir1), 64'(ir));
        checkOutput("out_valid_lsb", 64'(ov0), 64'(mActive));
        checkOutput("out_valid_msb", 64'(ov1), 64'(mActive));
        checkOutput("busy_lsb",      64'(bz0), 64'(mActive));
        checkOutput("busy_msb",      64'(bz1), 64'(mActive));
        checkOutput("first_lsb",     64'(of0), 64'(mActive && mPos == 0));
        checkOutput("first_msb",     64'(of1), 64'(mActive && mPos == 0));
        checkOutput("last_lsb",      64'(ol0), 64'(mActive && mPos == 7));
        checkOutput("last_msb",      64'(ol1), 64'(mActive && mPos == 7));
        checkOutput("count_lsb",     64'(wc0), 64'(mCount));
        checkOutput("count_msb",     64'(wc1), 64'(mCount));
        if (mActive) begin
            bLsb = mWord[mPos*8 +: 8];
            bMsb = mWord[(7-mPos)*8 +: 8];
            checkOutput("data_lsb", 64'(od0), 64'(bLsb));
            checkOutput("data_msb", 64'(od1), 64'(bMsb));
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic modelStep();
        bit inBeat;
        bit outBeat;
        if (!reset) begin
            mActive = 1'b0;
            mPos    = 0;
            mCount  = '0;
            return;
        end
        inBeat  = in_valid && expInReady();
        outBeat = mActive && out_ready;
        if (abort) begin
            mActive = 1'b0;
        end else begin
            if (outBeat) begin
                if (mPos == 7) begin
                    mCount++;
                    mActive = 1'b0;
                end else begin
                    mPos++;
                end
            end
            if (inBeat) begin
                mWord   = in_data;
                mPos    = 0;
                mActive = 1'b1;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check shortly afterwards,
    // then advance the model across the rising edge.
    task automatic applyStimulus(input bit v, input logic [63:0] d, input bit r, input bit a);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        abort     = a;
        #1;
        compareAll();
        @(posedge clk);
        modelStep();
    endtask

    task automatic releaseReset();
        @(negedge clk);
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk);
        modelStep();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [63:0] w;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        abort     = 1'b0;
        mActive   = 1'b0;
        mWord     = '0;
        mPos      = 0;
        mCount    = '0;

        // Held in reset with a word offered: nothing may be accepted.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'hDEAD_BEEF_0000_1111, 1'b1, 1'b0);
        releaseReset();

        // Single word, no backpressure.
        $display("[TB] single word");
        applyStimulus(1'b1, 64'h8877665544332211, 1'b1, 1'b0);
        idleCycles(9);
        checkOutput("count_after_single", 64'(wc0), 64'd1);

        // Backpressure for three cycles on byte 33, with in_valid toggling.
        $display("[TB] backpressure");
        applyStimulus(1'b1, 64'h8877665544332211, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        idleCycles(8);
        checkOutput("count_after_bp", 64'(wc0), 64'd2);

        // Back-to-back words with in_valid held high.
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 64'h0807060504030201, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 64'h1817161514131211, 1'b1, 1'b0);
        idleCycles(9);
        checkOutput("count_after_b2b", 64'(wc0), 64'd4);

        // Word for the MSB-first ordering check.
        applyStimulus(1'b1, 64'hA1B2C3D4E5F60718, 1'b1, 1'b0);
        idleCycles(9);

        // Abort while byte 55 (index 4) is presented, then an all-zero word.
        $display("[TB] abort");
        applyStimulus(1'b1, 64'h8877665544332211, 1'b1, 1'b0);
        idleCycles(4);
        applyStimulus(1'b1, 64'h5555_5555_5555_5555, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h0, 1'b1, 1'b0);
        idleCycles(9);

        // Abort coinciding with the final byte beat: no count, no accept.
        applyStimulus(1'b1, 64'hCAFE_F00D_1234_5678, 1'b1, 1'b0);
        idleCycles(7);
        applyStimulus(1'b1, 64'h9999_9999_9999_9999, 1'b1, 1'b1);
        idleCycles(2);
        checkOutput("count_after_aborts", 64'(wc0), 64'd6);

        // Asynchronous reset mid-word at index 5.
        $display("[TB] async reset mid-word");
        w = 64'h8877665544332211;
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        idleCycles(5);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        abort     = 1'b0;
        #1;
        compareAll();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(ov0), 64'd0);
        checkOutput("rst_in_ready",  64'(ir0), 64'd0);
        checkOutput("rst_count",     64'(wc0), 64'd0);
        checkOutput("rst_out_last",  64'(ol0), 64'd0);
        modelStep();
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        applyStimulus(1'b1, w, 1'b1, 1'b0);
        releaseReset();
        applyStimulus(1'b1, 64'h0F0E0D0C0B0A0908, 1'b1, 1'b0);
        idleCycles(9);
        checkOutput("count_after_restart", 64'(wc0), 64'd1);

        // Randomized traffic with backpressure and occasional aborts.
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          {$urandom(), $urandom()},
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 29) == 0);
        end
        idleCycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
